dkong3_obj_dma: RTL and testbench
=================================

Name: dkong3_obj_dma

Overview:
- Object-RAM DMA engine: on CPU command, takes the CPU bus and copies the sprite attribute table from CPU work RAM into object RAM.
- Drives the object RAM write port (DMA address, data and write-enable) consumed by the sprite block.
- Transfers are byte-serial, paced by a clock enable, with a bus request/acknowledge handshake to the CPU.

Parameters:
- LEN, 384: bytes per transfer, 1..512.
- DST_BASE, 9'h000: object RAM start offset within the selected bank.

Ports:
- I_CLK_24M  in  1  system clock; all logic on rising edge.
- I_RESETn  in  1  asynchronous active-low reset.
- I_CE  in  1  step enable; state advances only on cycles with I_CE=1.
- I_CPU_WRn  in  1  register write strobe, active low, sampled on I_CE cycles.
- I_CPU_A  in  1  register select: 0 = source high byte, 1 = start.
- I_CPU_D  in  8  register write data.
- I_BANK  in  1  destination bank bit, latched at start.
- O_BUSRQn  out  1  bus request to CPU, active low.
- I_BUSAKn  in  1  bus acknowledge, active low.
- O_SRC_A  out  16  source read address.
- O_SRC_RDn  out  1  source read strobe, active low.
- I_SRC_D  in  8  source read data, valid at the end of the RD step.
- O_OBJ_DMA_A  out  10  object RAM write address {bank, offset}.
- O_OBJ_DMA_D  out  8  object RAM write data.
- O_OBJ_DMA_CE  out  1  object RAM write enable, one I_CLK_24M cycle per byte.
- O_BUSY  out  1  high from start accepted until bus released.
- O_DONE  out  1  one-cycle pulse on completion.

Behaviour:
- Reset values (async, immediate): O_BUSRQn=1, O_SRC_RDn=1, O_OBJ_DMA_CE=0, O_BUSY=0, O_DONE=0, O_SRC_A=0, O_OBJ_DMA_A=0, O_OBJ_DMA_D=0. Also cleared: source high byte register, index, state=IDLE.
- Register writes: I_CPU_WRn=0 with I_CE=1.
  - A=0 loads SRC_HI at any time. An in-flight transfer uses its start-time copy.
  - A=1 is a start; I_CPU_D is ignored.
- States:
  - IDLE: on start, latch SRC_HI and I_BANK, clear 9-bit index, set O_BUSY=1 and O_BUSRQn=0 -> REQ.
  - REQ: wait for I_BUSAKn=0 on an I_CE cycle -> RD.
  - RD: O_SRC_A={SRC_HI_latched,8'h00}+index (16-bit add, wraps FFFF->0000), O_SRC_RDn=0. On next I_CE with I_BUSAKn=0: capture I_SRC_D into O_OBJ_DMA_D, set O_SRC_RDn=1 -> WR. If I_BUSAKn=1, hold in RD with O_SRC_RDn=1 until re-granted.
  - WR: O_OBJ_DMA_A={bank_latched, DST_BASE+index (9-bit, wraps)}. O_OBJ_DMA_CE=1 for exactly the one I_CLK_24M cycle where I_CE=1. Then increment index. If index was LEN-1 -> REL, else -> RD.
  - REL: O_BUSRQn=1, O_BUSY=0, O_DONE=1 for one cycle -> IDLE.
- Throughput: 2 I_CE steps per byte. Total = grant wait + 2*LEN + 1 steps.
- Start while O_BUSY=1: ignored, no restart, no queue.
- Register write and state transition on the same cycle: both take effect.
- Reset mid-transfer: abort immediately. O_BUSRQn releases with no further write pulses. Partial object RAM contents are left as written.
- O_OBJ_DMA_A/D hold their values outside WR. Only O_OBJ_DMA_CE qualifies a write.
- Exactly LEN write pulses per transfer, never zero. Index range 0..LEN-1.

Test Plan:
- Reset: hold I_RESETn=0 mid-WR -> all outputs at reset values the same cycle; no O_OBJ_DMA_CE after release.
- Basic copy: SRC_HI=0x60, I_BANK=0, start, I_BUSAKn=0 after 3 steps, source memory returns low address byte -> 384 pulses, addr 0x000..0x17F, data = addr[7:0], O_DONE once, O_BUSRQn=1 after.
- Bank/wrap: SRC_HI=0xFF, I_BANK=1, LEN=384 -> O_SRC_A goes FFFF then 0000..007F; O_OBJ_DMA_A = 0x200..0x37F.
- Bus steal: deassert I_BUSAKn during byte 10 for 5 steps -> O_SRC_RDn=1, no pulses while released, resumes at byte 10, no byte skipped or duplicated.
- Start while busy plus SRC_HI rewrite to 0x70 mid-transfer -> current transfer continues from 0x60xx, no restart; next start reads from 0x7000.
- Timing: no grant delay, LEN=384 -> O_DONE exactly 1+1+768+1 I_CE steps after start; O_OBJ_DMA_CE width is 1 clock.

Source files
------------

// File: rtl/dkong3_obj_dma.sv
// Object-RAM DMA engine: requests the CPU bus and copies LEN bytes from CPU work RAM
// into the selected object RAM bank, one byte every two I_CE steps.
module dkong3_obj_dma #(
    parameter int unsigned LEN      = 384,
    parameter logic [8:0]  DST_BASE = 9'h000
) (
    input  logic        I_CLK_24M,
    input  logic        I_RESETn,
    input  logic        I_CE,
    input  logic        I_CPU_WRn,
    input  logic        I_CPU_A,
    input  logic [7:0]  I_CPU_D,
    input  logic        I_BANK,
    output logic        O_BUSRQn,
    input  logic        I_BUSAKn,
    output logic [15:0] O_SRC_A,
    output logic        O_SRC_RDn,
    input  logic [7:0]  I_SRC_D,
    output logic [9:0]  O_OBJ_DMA_A,
    output logic [7:0]  O_OBJ_DMA_D,
    output logic        O_OBJ_DMA_CE,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_REL
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

    state_t      state_q;
    logic [7:0]  src_hi_q;
    logic [7:0]  src_hi_lat_q;
    logic        bank_q;
    logic [8:0]  idx_q;
    logic        busrq_n_q;
    logic        rd_n_q;
    logic        obj_ce_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] src_a_q;
    logic [9:0]  obj_a_q;
    logic [7:0]  obj_d_q;

    logic        reg_wr;
    logic        start;
    logic        hi_wr;
    logic [8:0]  idx_d;
    logic [15:0] src_a_d;
    logic [8:0]  dst_off_d;

    assign reg_wr    = I_CE & ~I_CPU_WRn;
    assign start     = reg_wr & I_CPU_A;
    assign hi_wr     = reg_wr & ~I_CPU_A;
    assign idx_d     = idx_q + 9'd1;
    assign src_a_d   = {src_hi_lat_q, 8'h00} + {7'b0, idx_d};
    assign dst_off_d = DST_BASE + idx_q;

    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q      <= S_IDLE;
            src_hi_q     <= '0;
            src_hi_lat_q <= '0;
            bank_q       <= 1'b0;
            idx_q        <= '0;
            busrq_n_q    <= 1'b1;
            rd_n_q       <= 1'b1;
            obj_ce_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            src_a_q      <= '0;
            obj_a_q      <= '0;
            obj_d_q      <= '0;
        end else begin
            // Pulses last one system clock regardless of the I_CE rate.
            obj_ce_q <= 1'b0;
            done_q   <= 1'b0;
            if (hi_wr) begin
                src_hi_q <= I_CPU_D;
            end
            if (I_CE) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            src_hi_lat_q <= src_hi_q;
                            bank_q       <= I_BANK;
                            idx_q        <= '0;
                            busy_q       <= 1'b1;
                            busrq_n_q    <= 1'b0;
                            state_q      <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (!I_BUSAKn) begin
                            src_a_q <= {src_hi_lat_q, 8'h00};
                            rd_n_q  <= 1'b0;
                            state_q <= S_RD;
                        end
                    end
                    S_RD: begin
                        // A lost grant drops the strobe; on re-grant the read step is repeated.
                        if (I_BUSAKn) begin
                            rd_n_q <= 1'b1;
                        end else if (rd_n_q) begin
                            rd_n_q <= 1'b0;
                        end else begin
                            obj_d_q <= I_SRC_D;
                            obj_a_q <= {bank_q, dst_off_d};
                            rd_n_q  <= 1'b1;
                            state_q <= S_WR;
                        end
                    end
                    S_WR: begin
                        if (!I_BUSAKn) begin
                            obj_ce_q <= 1'b1;
                            if (idx_q == LAST_IDX) begin
                                busrq_n_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= S_REL;
                            end else begin
                                idx_q   <= idx_d;
                                src_a_q <= src_a_d;
                                rd_n_q  <= 1'b0;
                                state_q <= S_RD;
                            end
                        end
                    end
                    S_REL: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign O_BUSRQn     = busrq_n_q;
    assign O_SRC_A      = src_a_q;
    assign O_SRC_RDn    = rd_n_q;
    assign O_OBJ_DMA_A  = obj_a_q;
    assign O_OBJ_DMA_D  = obj_d_q;
    assign O_OBJ_DMA_CE = obj_ce_q;
    assign O_BUSY       = busy_q;
    assign O_DONE       = done_q;

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// Directed bench for dkong3_obj_dma: copy, start-while-busy, bus steal, bank/wrap,
// step timing and reset abort, against a source memory that returns the low address byte.
module tb_dkong3_obj_dma;

    logic        clk;
    logic        I_RESETn;
    logic        I_CE;
    logic        I_CPU_WRn;
    logic        I_CPU_A;
    logic [7:0]  I_CPU_D;
    logic        I_BANK;
    logic        O_BUSRQn;
    logic        I_BUSAKn;
    logic [15:0] O_SRC_A;
    logic        O_SRC_RDn;
    logic [7:0]  I_SRC_D;
    logic [9:0]  O_OBJ_DMA_A;
    logic [7:0]  O_OBJ_DMA_D;
    logic        O_OBJ_DMA_CE;
    logic        O_BUSY;
    logic        O_DONE;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int width_err = 0;
    int cecnt = 0;
    int steps;
    int nrec;
    logic ce_prev = 1'b0;
    logic [15:0] last_rd = '0;
    logic [33:0] rec[$];

    dkong3_obj_dma #(.LEN(384), .DST_BASE(9'h000)) dut (
        .I_CLK_24M   (clk),
        .I_RESETn    (I_RESETn),
        .I_CE        (I_CE),
        .I_CPU_WRn   (I_CPU_WRn),
        .I_CPU_A     (I_CPU_A),
        .I_CPU_D     (I_CPU_D),
        .I_BANK      (I_BANK),
        .O_BUSRQn    (O_BUSRQn),
        .I_BUSAKn    (I_BUSAKn),
        .O_SRC_A     (O_SRC_A),
        .O_SRC_RDn   (O_SRC_RDn),
        .I_SRC_D     (I_SRC_D),
        .O_OBJ_DMA_A (O_OBJ_DMA_A),
        .O_OBJ_DMA_D (O_OBJ_DMA_D),
        .O_OBJ_DMA_CE(O_OBJ_DMA_CE),
        .O_BUSY      (O_BUSY),
        .O_DONE      (O_DONE)
    );

    assign I_SRC_D = O_SRC_A[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One I_CE step every third clock so a one-clock write pulse is distinguishable.
    initial I_CE = 1'b0;
    always @(negedge clk) begin
        cecnt = (cecnt + 1) % 3;
        I_CE  = (cecnt == 0);
    end

    always @(negedge clk) begin
        if (O_OBJ_DMA_CE) begin
            rec.push_back({last_rd, O_OBJ_DMA_A, O_OBJ_DMA_D});
            if (ce_prev) width_err++;
        end
        ce_prev = O_OBJ_DMA_CE;
        if (!O_SRC_RDn) last_rd = O_SRC_A;
        if (O_DONE) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        do @(posedge clk); while (!I_CE);
        #1;
    endtask

    task automatic cpu_wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        I_CPU_WRn = 1'b0;
        I_CPU_A   = a;
        I_CPU_D   = d;
        do @(posedge clk); while (!I_CE);
        @(negedge clk);
        I_CPU_WRn = 1'b1;
    endtask

    task automatic wait_pulses(input string tag, input int n);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (rec.size() >= n) break;
        end
        chk(tag, 32'(rec.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic verify(input string tag, input int n, input logic [15:0] sbase, input logic [9:0] obase);
        int bad;
        logic [15:0] s;
        logic [9:0]  o;
        bad = 0;
        chk({tag, "_count"}, rec.size(), n);
        for (int i = 0; i < rec.size() && i < n; i++) begin
            s = sbase + 16'(i);
            o = obase + 10'(i);
            if (rec[i] !== {s, o, s[7:0]}) bad++;
        end
        chk({tag, "_seq"}, bad, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busrq"}, O_BUSRQn, 1);
        chk({tag, "_rdn"}, O_SRC_RDn, 1);
        chk({tag, "_ce"}, O_OBJ_DMA_CE, 0);
        chk({tag, "_busy"}, O_BUSY, 0);
        chk({tag, "_done"}, O_DONE, 0);
        chk({tag, "_srca"}, O_SRC_A, 0);
        chk({tag, "_obja"}, O_OBJ_DMA_A, 0);
        chk({tag, "_objd"}, O_OBJ_DMA_D, 0);
    endtask

    initial begin
        I_RESETn  = 1'b0;
        I_CPU_WRn = 1'b1;
        I_CPU_A   = 1'b0;
        I_CPU_D   = '0;
        I_BANK    = 1'b0;
        I_BUSAKn  = 1'b1;
        #12;
        chk_reset("rst");
        @(negedge clk);
        I_RESETn = 1'b1;

        // Basic copy from 0x6000, grant after 3 steps, start and SRC_HI rewrite mid-transfer
        cpu_wr(1'b0, 8'h60);
        I_BANK = 1'b0;
        cpu_wr(1'b1, 8'hA5);
        chk("start_busy", O_BUSY, 1);
        chk("start_busrq", O_BUSRQn, 0);
        repeat (3) step();
        chk("req_no_pulse", rec.size(), 0);
        chk("req_rdn", O_SRC_RDn, 1);
        chk("req_busrq", O_BUSRQn, 0);
        @(negedge clk);
        I_BUSAKn = 1'b0;
        wait_pulses("copy_mid", 100);
        cpu_wr(1'b0, 8'h70);
        cpu_wr(1'b1, 8'h00);
        chk("copy_still_busy", O_BUSY, 1);
        wait_done("copy_done", 1);
        chk("copy_busrq_rel", O_BUSRQn, 1);
        chk("copy_busy_rel", O_BUSY, 0);
        verify("copy", 384, 16'h6000, 10'h000);
        repeat (10) step();
        chk("no_restart", rec.size(), 384);
        chk("done_once", done_cnt, 1);

        // Next start uses 0x70; bus stolen during byte 10 for 5 steps
        rec.delete();
        cpu_wr(1'b1, 8'h00);
        wait_pulses("steal_reach", 10);
        I_BUSAKn = 1'b1;
        step();
        chk("steal_rdn", O_SRC_RDn, 1);
        chk("steal_srca", O_SRC_A, 16'h700A);
        repeat (5) step();
        chk("steal_no_pulse", rec.size(), 10);
        chk("steal_rdn_hold", O_SRC_RDn, 1);
        @(negedge clk);
        I_BUSAKn = 1'b0;
        wait_done("steal_done", 2);
        verify("steal", 384, 16'h7000, 10'h000);

        // Source wrap from 0xFF00 into bank 1, no grant delay, step count to O_DONE
        rec.delete();
        cpu_wr(1'b0, 8'hFF);
        I_BANK = 1'b1;
        @(negedge clk);
        I_CPU_WRn = 1'b0;
        I_CPU_A   = 1'b1;
        do @(posedge clk); while (!I_CE);
        #1;
        steps = 1;
        @(negedge clk);
        I_CPU_WRn = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            steps++;
            if (O_DONE) break;
        end
        chk("timing_steps", steps, 771);
        wait_done("wrap_done", 3);
        verify("wrap", 384, 16'hFF00, 10'h200);
        chk("pulse_width", width_err, 0);

        // Reset asserted while in WR aborts at once
        rec.delete();
        cpu_wr(1'b1, 8'h00);
        for (int i = 0; i < 200; i++) begin
            step();
            if (rec.size() >= 5 && O_SRC_RDn && O_BUSY) break;
        end
        chk("abort_in_wr", 32'(rec.size() >= 5 && O_SRC_RDn && O_BUSY), 32'd1);
        I_RESETn = 1'b0;
        #1;
        chk_reset("abort");
        nrec = rec.size();
        repeat (4) @(negedge clk);
        I_RESETn = 1'b1;
        repeat (50) step();
        chk("abort_no_pulse", rec.size(), nrec);
        chk("abort_busrq", O_BUSRQn, 1);
        chk("abort_busy", O_BUSY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
